matrix_multiplier_param: RTL and testbench
==========================================

Name: matrix_multiplier_param

Overview:
- Parametrised successor to the fixed 2x2 / 3-bit matrix multiplier.
- Computes C = A x B, or C = A x B + C_prev in accumulate mode, for N x N unsigned matrices of EW-bit elements.
- Uses one shared multiply-accumulate (MAC) datapath, sequenced by an internal FSM: one MAC per cycle, N^3 cycles per operation.
- Sits where the fixed multiplier sat, driven by the same clock/reset/start control; adds busy/done handshake and an operation counter.

Parameters:
- N, 2, matrix dimension (rows = columns), N >= 1
- EW, 3, element width of A and B, unsigned
- CW, 4, width of completed-operation counter
- RW (localparam), 2*EW + clog2(N) (0 when N=1), result element width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- acc_mode  in  1  sampled with start: 0 = C=AxB, 1 = C=AxB+C_prev
- matrix_a  in  N*N*EW  A; element (r,c) at bits [(r*N+c)*EW +: EW]
- matrix_b  in  N*N*EW  B, same packing
- busy  out  1  high while computing
- done  out  1  one-cycle pulse when matrix_result updates
- matrix_result  out  N*N*RW  C, same packing with RW
- matrix_count  out  CW  number of completed operations, wraps mod 2^CW

Behaviour:
- Reset (sync, any state, including mid-operation):
  - FSM goes to IDLE.
  - busy=0, done=0, matrix_result=0, matrix_count=0.
  - Indices, accumulator and working result cleared.
  - Any partial operation is discarded.
- States: IDLE, MAC, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1 at the edge: register matrix_a, matrix_b and acc_mode; set i=j=k=0; go to MAC.
  - matrix_a/matrix_b may change freely after that edge.
- MAC (busy=1), one term per cycle:
  - sum = base + a[i][k]*b[k][j].
  - base = (k==0) ? (acc_mode_q ? matrix_result[i][j] : 0) : acc.
  - acc <= sum.
  - When k==N-1: working[i][j] <= sum[RW-1:0].
  - Index order: k fastest, then j, then i.
  - After i=j=k=N-1, go to DONE.
- Width rules:
  - Product is 2*EW bits, zero-extended to RW.
  - All adds are modulo 2^RW; wrap is silent and occurs only in accumulate mode.
- DONE (one cycle):
  - done=1, busy=0.
  - matrix_result is loaded from working at the MAC->DONE edge, so it is valid in the DONE cycle.
  - matrix_count increments at the same edge.
  - Next state is IDLE.
- Timing, with start sampled at the end of cycle t:
  - busy high in cycles t+1 .. t+N^3.
  - done high in cycle t+N^3+1.
  - Earliest next start is sampled at the end of cycle t+N^3+2.
- Ignored starts: start is ignored in MAC and DONE (no queueing).
  - Holding start high re-launches from IDLE every N^3+2 cycles.
- Output stability: matrix_result and matrix_count are stable except at the MAC->DONE edge.
  - Intermediate values never appear on matrix_result.
- N=1: MAC lasts exactly one cycle.

Decomposition:
- Shared package matrix_mult_pkg holds:
  - state encoding (IDLE, MAC, DONE);
  - RW computation function;
  - packing index helpers (elem offset = (r*N+c)*width).
- One sub-module: matrix_mac_unit.
  - Combinational, EW-bit x EW-bit product plus RW-bit base, giving an RW-bit sum.
  - Parametrised by EW and RW.
- FSM, index counters and registers stay in the top module.

Test Plan:
- Reset check: N=2, EW=3, reset asserted mid-MAC (cycle t+3) -> next cycle busy=0, done=0, matrix_result=0, matrix_count=0; a subsequent start completes normally.
- Basic multiply: A=[[1,2],[3,4]], B=[[5,6],[7,0]], acc_mode=0, start one cycle -> busy high for 8 cycles, done in cycle t+9, matrix_result=[[19,6],[43,18]], matrix_count=1.
- Max-value multiply: A=B=all 7, acc_mode=0 -> every element = 98 (RW=7, no overflow).
- Accumulate with wrap: repeat the max-value run with acc_mode=1 -> every element = (98+98) mod 128 = 68, matrix_count=2.
- Ignored start and operand capture: pulse start again during MAC and during DONE, and change matrix_a after capture -> no restart, result uses captured operands, count increments once.
- Back-to-back: hold start high for 3 operations with N=3, EW=4 -> done every 29 cycles, results match a reference model, matrix_count=3.

Source files
------------

// File: rtl/matrix_mult_pkg.sv
// Shared definitions for the parametrised matrix multiplier: FSM encoding,
// result width rule and flat-bus element offset helper.
package matrix_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Full-precision width of an N-term dot product of ew-bit operands.
    function automatic int calc_rw(input int n, input int ew);
        return 2 * ew + ((n > 1) ? $clog2(n) : 0);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int elem_off(input int r, input int c, input int n, input int w);
        return (r * n + c) * w;
    endfunction

endpackage

// File: rtl/matrix_mac_unit.sv
// Combinational multiply-accumulate: sum = base + a*b, modulo 2^RW.
// Zero latency; no flow control.
module matrix_mac_unit #(
    parameter int EW = 3,
    parameter int RW = 7
) (
    input  logic [EW-1:0] a,
    input  logic [EW-1:0] b,
    input  logic [RW-1:0] base,
    output logic [RW-1:0] sum
);

    logic [2*EW-1:0] prod;

    always_comb begin
        prod = {{EW{1'b0}}, a} * {{EW{1'b0}}, b};
        sum  = base + RW'(prod);
    end

endmodule

// File: rtl/matrix_multiplier_param.sv
// N x N unsigned matrix multiply (optionally accumulating into the last result) on one shared MAC.
// Latency N^3 + 1 cycles from accepted start to done; starts outside IDLE are dropped.
module matrix_multiplier_param
    import matrix_mult_pkg::*;
#(
    parameter int  N  = 2,
    parameter int  EW = 3,
    parameter int  CW = 4,
    localparam int RW = calc_rw(N, EW)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                acc_mode,
    input  logic [N*N*EW-1:0]   matrix_a,
    input  logic [N*N*EW-1:0]   matrix_b,
    output logic                busy,
    output logic                done,
    output logic [N*N*RW-1:0]   matrix_result,
    output logic [CW-1:0]       matrix_count
);

    localparam int              IW   = idx_w(N);
    localparam int              AW   = N * N * EW;
    localparam int              CRW  = N * N * RW;
    localparam logic [IW-1:0]   LAST = IW'(N - 1);

    state_t          state;
    state_t          state_nxt;

    logic [AW-1:0]   a_q;
    logic [AW-1:0]   b_q;
    logic            acc_mode_q;

    logic [IW-1:0]   i_idx;
    logic [IW-1:0]   j_idx;
    logic [IW-1:0]   k_idx;
    logic            k_last;
    logic            last_term;

    logic [EW-1:0]   a_el;
    logic [EW-1:0]   b_el;
    logic [RW-1:0]   acc;
    logic [RW-1:0]   base;
    logic [RW-1:0]   sum;
    logic [CRW-1:0]  working;
    logic [CRW-1:0]  working_nxt;

    always_comb begin
        k_last    = (k_idx == LAST);
        last_term = k_last && (j_idx == LAST) && (i_idx == LAST);
        a_el      = a_q[elem_off(int'(i_idx), int'(k_idx), N, EW) +: EW];
        b_el      = b_q[elem_off(int'(k_idx), int'(j_idx), N, EW) +: EW];
    end

    // First term of each dot product seeds from the previous result (accumulate) or zero.
    always_comb begin
        base = acc;
        if (k_idx == '0) begin
            if (acc_mode_q) begin
                base = matrix_result[elem_off(int'(i_idx), int'(j_idx), N, RW) +: RW];
            end else begin
                base = '0;
            end
        end
    end

    matrix_mac_unit #(
        .EW (EW),
        .RW (RW)
    ) u_mac (
        .a    (a_el),
        .b    (b_el),
        .base (base),
        .sum  (sum)
    );

    always_comb begin
        working_nxt = working;
        if (state == ST_MAC && k_last) begin
            working_nxt[elem_off(int'(i_idx), int'(j_idx), N, RW) +: RW] = sum;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_MAC;
            ST_MAC:  if (last_term) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_MAC);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q           <= '0;
            b_q           <= '0;
            acc_mode_q    <= 1'b0;
            i_idx         <= '0;
            j_idx         <= '0;
            k_idx         <= '0;
            acc           <= '0;
            working       <= '0;
            matrix_result <= '0;
            matrix_count  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q        <= matrix_a;
                        b_q        <= matrix_b;
                        acc_mode_q <= acc_mode;
                        i_idx      <= '0;
                        j_idx      <= '0;
                        k_idx      <= '0;
                        acc        <= '0;
                    end
                end
                ST_MAC: begin
                    acc     <= sum;
                    working <= working_nxt;
                    // k runs fastest, then j, then i.
                    if (k_last) begin
                        k_idx <= '0;
                        if (j_idx == LAST) begin
                            j_idx <= '0;
                            i_idx <= (i_idx == LAST) ? '0 : i_idx + IW'(1);
                        end else begin
                            j_idx <= j_idx + IW'(1);
                        end
                    end else begin
                        k_idx <= k_idx + IW'(1);
                    end
                    // Result is published only once complete, so it never shows partial sums.
                    if (last_term) begin
                        matrix_result <= working_nxt;
                        matrix_count  <= matrix_count + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_multiplier_param.sv
// Randomised scoreboard bench for matrix_multiplier_param at N=2/EW=3 and N=3/EW=4.
module tb_matrix_multiplier_param;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst2, start2, accm2, busy2, done2;
    logic [11:0] a2, b2;
    logic [27:0] res2;
    logic [3:0]  cnt2;

    logic        rst3, start3, accm3, busy3, done3;
    logic [35:0] a3, b3;
    logic [89:0] res3;
    logic [3:0]  cnt3;

    matrix_multiplier_param #(.N(2), .EW(3), .CW(4)) dut2 (
        .clock(clock), .reset(rst2), .start(start2), .acc_mode(accm2),
        .matrix_a(a2), .matrix_b(b2), .busy(busy2), .done(done2),
        .matrix_result(res2), .matrix_count(cnt2)
    );

    matrix_multiplier_param #(.N(3), .EW(4), .CW(4)) dut3 (
        .clock(clock), .reset(rst3), .start(start3), .acc_mode(accm3),
        .matrix_a(a3), .matrix_b(b3), .busy(busy3), .done(done3),
        .matrix_result(res3), .matrix_count(cnt3)
    );

    // Expected results are held with 10 bits per element regardless of instance.
    typedef struct packed {
        logic [89:0] res;
        logic [31:0] cnt;
        logic [31:0] done_cyc;
    } exp_t;

    exp_t q2[$];
    exp_t q3[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int opa[2][9];
    int opb[2][9];
    int prev[2][9];
    int mcnt[2];
    int next_ok[2];
    int accepted[2];
    int run[2];
    bit rprev[2];
    int last_res[2][9];
    int last_cnt[2];
    logic [89:0] n2;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int dimn(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int ewv(input int d);
        return (d == 0) ? 3 : 4;
    endfunction

    function automatic int rwv(input int d);
        return (d == 0) ? 7 : 10;
    endfunction

    task automatic chk(input int d, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (N=%0d, cycle %0d): got %0d, expected %0d", name, dimn(d), cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rand_ops(input int d);
        for (int e = 0; e < 9; e++) begin
            opa[d][e] = int'($urandom_range(0, (1 << ewv(d)) - 1));
            opb[d][e] = int'($urandom_range(0, (1 << ewv(d)) - 1));
        end
    endtask

    // Drives one instance for the coming edge and updates the reference model for that edge.
    task automatic drive(input int d, input bit st, input bit am, input bit rs);
        int   n;
        int   s;
        exp_t x;
        n = dimn(d);
        if (d == 0) begin
            for (int e = 0; e < 4; e++) begin
                a2[e*3 +: 3] = 3'(opa[0][e]);
                b2[e*3 +: 3] = 3'(opb[0][e]);
            end
            start2 = st; accm2 = am; rst2 = rs;
        end else begin
            for (int e = 0; e < 9; e++) begin
                a3[e*4 +: 4] = 4'(opa[1][e]);
                b3[e*4 +: 4] = 4'(opb[1][e]);
            end
            start3 = st; accm3 = am; rst3 = rs;
        end
        if (rs) begin
            if (d == 0) q2.delete(); else q3.delete();
            for (int e = 0; e < 9; e++) prev[d][e] = 0;
            mcnt[d]    = 0;
            next_ok[d] = cyc + 2;
        end else if (st && (cyc + 1 >= next_ok[d])) begin
            x = '0;
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < n; j++) begin
                    s = am ? prev[d][i*n+j] : 0;
                    for (int k = 0; k < n; k++) s += opa[d][i*n+k] * opb[d][k*n+j];
                    s = s % (1 << rwv(d));
                    prev[d][i*n+j] = s;
                    x.res[(i*n+j)*10 +: 10] = 10'(s);
                end
            end
            mcnt[d]    = (mcnt[d] + 1) % 16;
            x.cnt      = 32'(mcnt[d]);
            x.done_cyc = 32'(cyc + 1 + n*n*n);
            next_ok[d] = cyc + 1 + n*n*n + 2;
            accepted[d]++;
            if (d == 0) q2.push_back(x); else q3.push_back(x);
        end
    endtask

    task automatic op(input int d, input bit am);
        int n;
        n = dimn(d);
        tick(); drive(d, 1'b1, am, 1'b0);
        tick(); drive(d, 1'b0, am, 1'b0);
        repeat (n*n*n) begin
            tick(); drive(d, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic mon(input int d, input logic b, input logic dn, input logic [89:0] rp,
                       input int c, input logic rs);
        int   n;
        exp_t x;
        bit   empty;
        n = dimn(d);
        if (rprev[d]) begin
            chk(d, "reset_busy", int'(b), 0);
            chk(d, "reset_done", int'(dn), 0);
            chk(d, "reset_count", c, 0);
            for (int e = 0; e < n*n; e++) chk(d, "reset_result", int'(rp[e*10 +: 10]), 0);
            for (int e = 0; e < 9; e++) last_res[d][e] = 0;
            last_cnt[d] = 0;
            run[d]      = 0;
        end else begin
            if (b) begin
                run[d]++;
                chk(d, "busy_and_done", int'(dn), 0);
            end
            if (dn) begin
                empty = (d == 0) ? (q2.size() == 0) : (q3.size() == 0);
                checks++;
                if (empty) begin
                    errors++;
                    $display("FAIL unexpected_done (N=%0d, cycle %0d): got done=1, expected none pending", n, cyc);
                end else begin
                    x = (d == 0) ? q2.pop_front() : q3.pop_front();
                    chk(d, "done_cycle", cyc, int'(x.done_cyc));
                    chk(d, "busy_length", run[d], n*n*n);
                    chk(d, "count", c, int'(x.cnt));
                    for (int e = 0; e < n*n; e++)
                        chk(d, "result", int'(rp[e*10 +: 10]), int'(x.res[e*10 +: 10]));
                end
                run[d] = 0;
                for (int e = 0; e < n*n; e++) last_res[d][e] = int'(rp[e*10 +: 10]);
                last_cnt[d] = c;
            end else begin
                chk(d, "count_stable", c, last_cnt[d]);
                for (int e = 0; e < n*n; e++) chk(d, "result_stable", int'(rp[e*10 +: 10]), last_res[d][e]);
            end
        end
        rprev[d] = rs;
    endtask

    always @(negedge clock) begin
        n2 = '0;
        for (int e = 0; e < 4; e++) n2[e*10 +: 10] = 10'(res2[e*7 +: 7]);
        mon(0, busy2, done2, n2, int'(cnt2), rst2);
        mon(1, busy3, done3, res3, int'(cnt3), rst3);
    end

    initial begin
        int c0;
        int base_acc;
        int guard;
        rprev[0] = 1'b1;
        rprev[1] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int e = 0; e < 9; e++) begin
                opa[d][e] = 0; opb[d][e] = 0; prev[d][e] = 0; last_res[d][e] = 0;
            end
            mcnt[d] = 0; next_ok[d] = 0; accepted[d] = 0; run[d] = 0; last_cnt[d] = 0;
        end
        drive(0, 1'b0, 1'b0, 1'b1);
        drive(1, 1'b0, 1'b0, 1'b1);
        tick(); drive(0, 1'b0, 1'b0, 1'b1); drive(1, 1'b0, 1'b0, 1'b1);
        tick(); drive(0, 1'b0, 1'b0, 1'b0); drive(1, 1'b0, 1'b0, 1'b0);

        // Reset three cycles into a MAC sequence; the aborted result must never appear.
        rand_ops(0);
        tick(); drive(0, 1'b1, 1'b0, 1'b0);
        tick(); drive(0, 1'b0, 1'b0, 1'b0);
        tick(); drive(0, 1'b0, 1'b0, 1'b0);
        tick(); drive(0, 1'b0, 1'b0, 1'b1);
        tick(); drive(0, 1'b0, 1'b0, 1'b0);

        // A=[[1,2],[3,4]], B=[[5,6],[7,0]]
        opa[0][0] = 1; opa[0][1] = 2; opa[0][2] = 3; opa[0][3] = 4;
        opb[0][0] = 5; opb[0][1] = 6; opb[0][2] = 7; opb[0][3] = 0;
        op(0, 1'b0);

        for (int e = 0; e < 4; e++) begin
            opa[0][e] = 7; opb[0][e] = 7;
        end
        op(0, 1'b0);
        op(0, 1'b1);

        // Extra starts in MAC and DONE, operands scrambled after capture.
        rand_ops(0);
        tick(); drive(0, 1'b1, 1'b0, 1'b0);
        for (int t = 1; t <= 10; t++) begin
            tick();
            rand_ops(0);
            drive(0, (t == 1) || (t == 9), 1'b1, 1'b0);
        end

        repeat (3) begin
            rand_ops(0);
            op(0, 1'($urandom_range(0, 1)));
        end

        // N=3: start held high, fresh random operands and mode every cycle.
        base_acc = accepted[1];
        guard    = 0;
        while (accepted[1] < base_acc + 3 && guard < 200) begin
            tick();
            rand_ops(1);
            drive(1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            guard++;
        end
        tick(); drive(1, 1'b0, 1'b0, 1'b0);
        c0 = cyc;
        while (q3.size() > 0 && cyc < c0 + 40) tick();

        rand_ops(1);
        op(1, 1'b1);

        c0 = cyc;
        while ((q2.size() + q3.size()) > 0 && cyc < c0 + 100) tick();
        chk(0, "pending_results", q2.size() + q3.size(), 0);
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
